// File: rtl/mem_stream_reader_pkg.sv
// mem_stream_reader_pkg: shared FSM encoding, buffer sizing and address-width helper
// for the mem stream reader and its output skid buffer.
package mem_stream_reader_pkg;

  // Burst controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Output buffer depth and the width of its occupancy count (0..BUF_DEPTH).
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

  // Address width for a mem of the given depth, matching the attached mem.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if: mem read port plus output valid/ready stream.
//   master (reader): drives rdaddress, rden, out_data, out_valid, out_last; takes q, out_ready.
//   slave  (mem + consumer): the mirror image.
interface mem_stream_reader_if
  import mem_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned AW = addr_width(DEPTH);

  logic [AW-1:0]    rdaddress;
  logic             rden;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output rdaddress, rden, out_data, out_valid, out_last,
    input  q, out_ready
  );

  modport slave (
    input  rdaddress, rden, out_data, out_valid, out_last,
    output q, out_ready
  );
endinterface

// File: rtl/mem_reader_skid.sv
// mem_reader_skid: 2-entry registered FIFO holding data+last; the head entry drives the
// registered stream outputs directly.
//   push/push_data/push_last : write one entry (caller guarantees space)
//   ready                    : consumer ready; pop = out_valid & ready
//   out_data/out_valid/out_last : head of FIFO
//   occupancy                : entries held (0..2)
module mem_reader_skid
  import mem_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [OCC_W-1:0] occupancy
);

  logic             pop;
  logic [WIDTH-1:0] tail_data;
  logic             tail_last;

  assign pop = out_valid & ready;

  // Head/tail update; the tail only ever feeds the head, so order is preserved.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
      occupancy <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == OCC_W'(0)) begin
            out_data  <= push_data;
            out_last  <= push_last;
            out_valid <= 1'b1;
          end else begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
          occupancy <= occupancy + OCC_W'(1);
        end
        2'b01: begin
          if (occupancy == OCC_W'(2)) begin
            out_data <= tail_data;
            out_last <= tail_last;
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          occupancy <= occupancy - OCC_W'(1);
        end
        2'b11: begin
          if (occupancy == OCC_W'(2)) begin
            out_data  <= tail_data;
            out_last  <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end else begin
            out_data <= push_data;
            out_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: drains a burst from a single-ported mem (1-cycle registered read)
// into a valid/ready stream without dropping words under backpressure.
//   clock, reset_n        : clock, async active-low reset
//   start/base_addr/count : burst request, sampled when idle
//   stride                : address increment, present only with MEM_READER_STRIDE_EN
//                           (otherwise the increment is 1)
//   busy, done            : burst in progress / one-cycle end-of-burst pulse
//   bus (master)          : rdaddress/rden/q to mem, out_data/out_valid/out_last/out_ready stream
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
`ifdef MEM_READER_STRIDE_EN
  input  logic [AW-1:0] stride,
`endif
  output logic          busy,
  output logic          done,
  mem_stream_reader_if.master bus
);

  localparam int unsigned SW = AW + 1;
  localparam int unsigned CW = OCC_W + 1;

  state_t           state, state_next;
  logic [AW-1:0]    step;
  logic [SW-1:0]    remaining;
  logic             in_flight;
  logic             in_flight_last;
  logic [OCC_W-1:0] occupancy;
  logic             pop;
  logic             credit_ok;
  logic             issue_c;
  logic [SW-1:0]    addr_sum;
  logic [AW-1:0]    addr_next;

  assign pop = bus.out_valid & bus.out_ready;

  // Buffered plus in-flight words may not exceed the buffer; a pop this cycle frees a slot.
  assign credit_ok = ((CW'(occupancy) + CW'(in_flight)) < CW'(BUF_DEPTH)) || pop;

  // Next address wraps modulo DEPTH, which need not be a power of two.
  assign addr_sum  = {1'b0, bus.rdaddress} + {1'b0, step};
  assign addr_next = (addr_sum >= SW'(DEPTH)) ? AW'(addr_sum - SW'(DEPTH)) : AW'(addr_sum);

  // Read strobe is issued in the same cycle the credit is available.
  assign bus.rden = issue_c;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // FSM next state and read issue.
  always_comb begin
    state_next = state;
    issue_c    = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = (count == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (credit_ok) begin
          issue_c = 1'b1;
          if (remaining == SW'(1)) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: if (pop && bus.out_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Address/remaining counters, in-flight tracking and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rdaddress  <= '0;
      remaining      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      busy           <= (state_next != ST_IDLE);
      done           <= (state_next == ST_DONE);
      in_flight      <= issue_c;
      in_flight_last <= issue_c && (remaining == SW'(1));
      if (state == ST_IDLE && start) begin
        bus.rdaddress <= base_addr;
        remaining     <= count;
      end else if (issue_c) begin
        bus.rdaddress <= addr_next;
        remaining     <= remaining - SW'(1);
      end
    end
  end

`ifdef MEM_READER_STRIDE_EN
  // Stride is captured with the burst request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  step <= '0;
    else if (state == ST_IDLE && start) step <= stride;
  end
`else
  assign step = AW'(1);
`endif

  // q is valid the cycle after rden, which is exactly when in_flight is set.
  mem_reader_skid #(.WIDTH(WIDTH)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_flight),
    .push_data (bus.q),
    .push_last (in_flight_last),
    .ready     (bus.out_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_last  (bus.out_last),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: directed bursts against a behavioural mem with mem[i] = i + 8'h10.
module tb_mem_stream_reader;
  import mem_stream_reader_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    int            stride;
    int            mode;       // 0: ready high, 1: random ready, 2: ready low for k<4
    bit            poke;       // pulse start while busy at k==1
    int            exp_first;
    int            exp_last;
    int            exp_done_k; // -1: only require done one cycle after last handshake
  } vec_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
`ifdef MEM_READER_STRIDE_EN
  logic [AW-1:0] stride = 6'd1;
`endif
  logic          busy;
  logic          done;
  logic [7:0]    mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  mem_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
`ifdef MEM_READER_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  // Behavioural mem: 1-cycle registered read.
  always_ff @(posedge clock) begin
    if (bus.rden) bus.q <= mem[bus.rdaddress];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_max(input string name, input int act, input int lim);
    n_vec++;
    if (act > lim) begin
      n_err++;
      $display("FAIL %s: got %0d, limit %0d", name, act, lim);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_rden"},      int'(bus.rden), 0);
    check({tag, "_rdaddress"}, int'(bus.rdaddress), 0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_last"},  int'(bus.out_last), 0);
    check({tag, "_out_data"},  int'(bus.out_data), 0);
  endtask

  // Run one burst; k counts cycles after the edge that samples start.
  task automatic run_burst(input vec_t v);
    int issued, popped, last_pop_k, done_k, ea, cnt, busy_at_done;
    logic pv, pr, pl;
    logic [7:0] pd, first_d, last_d;
    issued = 0; popped = 0; last_pop_k = -1; done_k = -1; busy_at_done = 0;
    cnt = int'(v.cnt);
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; first_d = '0; last_d = '0;
    @(negedge clock);
    start = 1'b1;
    base_addr = v.base;
    count = v.cnt;
`ifdef MEM_READER_STRIDE_EN
    stride = AW'(v.stride);
`endif
    bus.out_ready = (v.mode != 2);
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) @(negedge clock);
      if (v.poke) begin
        if (k == 1) begin
          start = 1'b1; base_addr = 6'd40; count = 7'd5;
        end else begin
          start = 1'b0;
        end
      end
      case (v.mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (k >= 4);
      endcase
      #1;
      if (bus.rden) begin
        ea = (int'(v.base) + issued * v.stride) % DEPTH;
        check("rdaddress", int'(bus.rdaddress), ea);
        issued++;
      end
      if (pv && !pr) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data",  int'(bus.out_data), int'(pd));
        check("stall_last",  int'(bus.out_last), int'(pl));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (popped < cnt) begin
          ea = (int'(v.base) + popped * v.stride) % DEPTH;
          check("out_data", int'(bus.out_data), ea + 16);
          check("out_last", int'(bus.out_last), (popped == cnt - 1) ? 1 : 0);
        end else begin
          check("extra_word", popped + 1, cnt);
        end
        if (popped == 0) first_d = bus.out_data;
        last_d = bus.out_data;
        last_pop_k = k;
        popped++;
      end
      check_max("in_flight_plus_occ", issued - popped, 2);
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
      if (done) begin
        done_k = k;
        busy_at_done = int'(busy);
        break;
      end
    end
    if (v.exp_done_k >= 0) check("done_cycle", done_k, v.exp_done_k);
    if (cnt > 0) check("done_after_last", done_k, last_pop_k + 1);
    check("busy_at_done", busy_at_done, 1);
    check("words_issued", issued, cnt);
    check("words_out", popped, cnt);
    if (cnt > 0) begin
      check("first_word", int'(first_d), v.exp_first);
      check("last_word",  int'(last_d), v.exp_last);
    end
    @(negedge clock);
    #1;
    check("done_pulse_end", int'(done), 0);
    check("busy_end", int'(busy), 0);
  endtask

  function automatic vec_t mk(input int base, input int cnt, input int stride, input int mode,
                              input bit poke, input int f, input int l, input int dk);
    vec_t v;
    v.base = AW'(base); v.cnt = (AW+1)'(cnt); v.stride = stride; v.mode = mode;
    v.poke = poke; v.exp_first = f; v.exp_last = l; v.exp_done_k = dk;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    vecs.push_back(mk(0,  4,  1, 0, 1'b0, 'h10, 'h13, 6));
    vecs.push_back(mk(5,  8,  1, 1, 1'b0, 'h15, 'h1C, -1));
    vecs.push_back(mk(62, 4,  1, 0, 1'b0, 'h4E, 'h11, 6));
    vecs.push_back(mk(0,  0,  1, 0, 1'b0, 0,    0,    0));
    vecs.push_back(mk(0,  64, 1, 0, 1'b0, 'h10, 'h4F, 66));
    vecs.push_back(mk(0,  3,  1, 2, 1'b1, 'h10, 'h12, -1));
`ifdef MEM_READER_STRIDE_EN
    vecs.push_back(mk(60, 3,  3, 0, 1'b0, 'h4C, 'h12, 5));
    vecs.push_back(mk(7,  3,  0, 0, 1'b0, 'h17, 'h17, 5));
`endif

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'(i + 'h10);
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    check_idle("reset");
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_burst(vecs[i]);

    // Reset in the middle of a count=10 burst after two words have left.
    @(negedge clock);
    start = 1'b1; base_addr = '0; count = 7'd10; bus.out_ready = 1'b1;
`ifdef MEM_READER_STRIDE_EN
    stride = 6'd1;
`endif
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    check("pre_reset_valid", int'(bus.out_valid), 1);
    check("pre_reset_data",  int'(bus.out_data), 'h12);
    #1;
    reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_burst(mk(0, 2, 1, 0, 1'b0, 'h10, 'h11, 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
